// File: rtl/inst_decode_if.sv
// Bundle of the signals between decode and its neighbours: fetch handshake,
// writeback and execute-forwarding inputs, and the operand/control bundle to execute.
interface inst_decode_if;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fwd_en;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        ex_valid;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [6:0]  opcode;
    logic [3:0]  fs;
    logic [4:0]  sh;
    logic        mw;
    logic [31:0] memaddr;
    logic [31:0] memdatain;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memtoreg;

    // Environment side: fetch, writeback and execute
    modport master (
        output in_valid, in_inst, wb_en, wb_rd, wb_data, fwd_en, fwd_rd, fwd_data,
        input  in_ready, ex_valid, busA, busB, opcode, fs, sh, mw, memaddr,
               memdatain, ex_rd, ex_regwrite, ex_memtoreg
    );

    // Decode stage side
    modport slave (
        input  in_valid, in_inst, wb_en, wb_rd, wb_data, fwd_en, fwd_rd, fwd_data,
        output in_ready, ex_valid, busA, busB, opcode, fs, sh, mw, memaddr,
               memdatain, ex_rd, ex_regwrite, ex_memtoreg
    );
endinterface

// File: rtl/inst_decode.sv
// Decode / operand-fetch stage: decodes the fetched instruction, reads the
// register file with execute forwarding and writeback bypass, stalls one cycle
// on a load-use hazard and registers the operand/control bundle for execute.
module inst_decode (
    input logic         clk,
    input logic         rst_n,
    inst_decode_if.slave bus
);
    localparam logic [3:0] FS_ADD = 4'h2;

    typedef enum logic [6:0] {
        OP_ALUR  = 7'h00,
        OP_ADDI  = 7'h01,
        OP_LOAD  = 7'h02,
        OP_STORE = 7'h03
    } op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] busA;
        logic [31:0] busB;
        logic [6:0]  opcode;
        logic [3:0]  fs;
        logic [4:0]  sh;
        logic        mw;
        logic [31:0] memaddr;
        logic [31:0] memdatain;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
    } bundle_t;

    logic [31:0] r_regs [32];
    bundle_t     r_ex;
    bundle_t     w_nxt;

    logic [6:0]  w_op;
    logic [4:0]  w_rd, w_rs, w_rt, w_sh;
    logic [3:0]  w_fs;
    logic [31:0] w_sext;
    logic [31:0] w_rs_val, w_rt_val, w_rd_val;
    logic        w_reads_ex;
    logic        w_hazard;

    assign w_op   = bus.in_inst[31:25];
    assign w_rd   = bus.in_inst[24:20];
    assign w_rs   = bus.in_inst[19:15];
    assign w_rt   = bus.in_inst[14:10];
    assign w_fs   = bus.in_inst[9:6];
    assign w_sh   = bus.in_inst[4:0];
    assign w_sext = {{17{bus.in_inst[14]}}, bus.in_inst[14:0]};

    // Priority: R0, then the younger execute result, then writeback, then the file
    function automatic logic [31:0] f_operand(
        input logic [4:0]  src,
        input logic [31:0] file_val,
        input logic        fe,
        input logic [4:0]  frd,
        input logic [31:0] fd,
        input logic        we,
        input logic [4:0]  wrd,
        input logic [31:0] wd
    );
        if (src == '0)                  return '0;
        else if (fe && (frd == src))    return fd;
        else if (we && (wrd == src))    return wd;
        else                            return file_val;
    endfunction

    assign w_rs_val = f_operand(w_rs, r_regs[w_rs], bus.fwd_en, bus.fwd_rd, bus.fwd_data,
                                bus.wb_en, bus.wb_rd, bus.wb_data);
    assign w_rt_val = f_operand(w_rt, r_regs[w_rt], bus.fwd_en, bus.fwd_rd, bus.fwd_data,
                                bus.wb_en, bus.wb_rd, bus.wb_data);
    assign w_rd_val = f_operand(w_rd, r_regs[w_rd], bus.fwd_en, bus.fwd_rd, bus.fwd_data,
                                bus.wb_en, bus.wb_rd, bus.wb_data);

    // A load in EX whose destination the incoming word reads cannot be bypassed yet
    assign w_reads_ex = (w_rs == r_ex.rd)
                      || ((w_op == OP_ALUR)  && (w_rt == r_ex.rd))
                      || ((w_op == OP_STORE) && (w_rd == r_ex.rd));
    assign w_hazard   = r_ex.valid && r_ex.memtoreg && (r_ex.rd != '0) && w_reads_ex;
    assign bus.in_ready = !w_hazard;

    // Next bundle: bubble on stall or no input, otherwise the decoded instruction
    always_comb begin
        w_nxt = '0;
        if (bus.in_valid && !w_hazard) begin
            w_nxt.valid = 1'b1;
            case (w_op)
                OP_ALUR: begin
                    w_nxt.opcode   = w_op;
                    w_nxt.busA     = w_rs_val;
                    w_nxt.busB     = w_rt_val;
                    w_nxt.fs       = w_fs;
                    w_nxt.sh       = w_sh;
                    w_nxt.rd       = w_rd;
                    w_nxt.regwrite = 1'b1;
                end
                OP_ADDI: begin
                    w_nxt.opcode   = w_op;
                    w_nxt.busA     = w_rs_val;
                    w_nxt.busB     = w_sext;
                    w_nxt.fs       = FS_ADD;
                    w_nxt.rd       = w_rd;
                    w_nxt.regwrite = 1'b1;
                end
                OP_LOAD: begin
                    w_nxt.opcode   = w_op;
                    w_nxt.busA     = w_rs_val;
                    w_nxt.busB     = w_sext;
                    w_nxt.fs       = FS_ADD;
                    w_nxt.memaddr  = w_rs_val + w_sext;
                    w_nxt.rd       = w_rd;
                    w_nxt.regwrite = 1'b1;
                    w_nxt.memtoreg = 1'b1;
                end
                OP_STORE: begin
                    w_nxt.opcode    = w_op;
                    w_nxt.busA      = w_rs_val;
                    w_nxt.busB      = w_sext;
                    w_nxt.fs        = FS_ADD;
                    w_nxt.memaddr   = w_rs_val + w_sext;
                    w_nxt.memdatain = w_rd_val;
                    w_nxt.mw        = 1'b1;
                    w_nxt.rd        = w_rd;
                end
                default: ;
            endcase
            if (w_rd == '0) w_nxt.regwrite = 1'b0;
        end
    end

    // Pipeline register feeding execute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ex <= '0;
        else        r_ex <= w_nxt;
    end

    // Register file; R0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (bus.wb_en && (bus.wb_rd != '0)) begin
            r_regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign bus.ex_valid    = r_ex.valid;
    assign bus.busA        = r_ex.busA;
    assign bus.busB        = r_ex.busB;
    assign bus.opcode      = r_ex.opcode;
    assign bus.fs          = r_ex.fs;
    assign bus.sh          = r_ex.sh;
    assign bus.mw          = r_ex.mw;
    assign bus.memaddr     = r_ex.memaddr;
    assign bus.memdatain   = r_ex.memdatain;
    assign bus.ex_rd       = r_ex.rd;
    assign bus.ex_regwrite = r_ex.regwrite;
    assign bus.ex_memtoreg = r_ex.memtoreg;
endmodule

// File: tb/tb_inst_decode.sv
// Scoreboard bench for inst_decode: directed instructions push hand-computed
// bundles; a negedge monitor pops and compares whenever ex_valid is high.
module tb_inst_decode;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_decode_if ifc ();
    inst_decode dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    typedef struct packed {
        logic [31:0] busA;
        logic [31:0] busB;
        logic [6:0]  opcode;
        logic [3:0]  fs;
        logic [4:0]  sh;
        logic        mw;
        logic [31:0] memaddr;
        logic [31:0] memdatain;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
    } exp_t;

    exp_t q[$];
    exp_t mon_a, mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b,
                                    input logic [6:0] op, input logic [3:0] fs,
                                    input logic [4:0] sh, input logic mw,
                                    input logic [31:0] ma, input logic [31:0] md,
                                    input logic [4:0] rd, input logic rw, input logic mt);
        exp_t e;
        e = '{busA: a, busB: b, opcode: op, fs: fs, sh: sh, mw: mw, memaddr: ma,
              memdatain: md, rd: rd, regwrite: rw, memtoreg: mt};
        return e;
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [3:0] fs,
                                         input logic [4:0] sh);
        return {7'h00, rd, rs, rt, fs, 1'b0, sh};
    endfunction

    function automatic logic [31:0] mk_i(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [14:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic fe, input logic [4:0] frd, input logic [31:0] fd);
        ifc.in_valid = v;   ifc.in_inst = inst;
        ifc.wb_en    = we;  ifc.wb_rd   = wrd;  ifc.wb_data  = wd;
        ifc.fwd_en   = fe;  ifc.fwd_rd  = frd;  ifc.fwd_data = fd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        drive(1'b0, '0, 1'b1, r, d, 1'b0, '0, '0);
        tick();
    endtask

    // Monitor: every real bundle must match the oldest expected one
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (ifc.ex_valid === 1'b1)) begin
                mon_a = '{busA: ifc.busA, busB: ifc.busB, opcode: ifc.opcode, fs: ifc.fs,
                          sh: ifc.sh, mw: ifc.mw, memaddr: ifc.memaddr,
                          memdatain: ifc.memdatain, rd: ifc.ex_rd,
                          regwrite: ifc.ex_regwrite, memtoreg: ifc.ex_memtoreg};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bundle: got %h required none", mon_a);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_a !== mon_e) begin
                        errors++;
                        $display("FAIL bundle: got %h required %h", mon_a, mon_e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_ex_valid", 32'(ifc.ex_valid), 32'd0);
        check("reset_busA", ifc.busA, 32'd0);
        check("reset_in_ready", 32'(ifc.in_ready), 32'd1);

        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd3);
        wb_write(5'd3, 32'h100);
        wb_write(5'd9, 32'hDEAD);
        wb_write(5'd0, 32'h55);

        // ALU-R from register file
        drive(1'b1, mk_r(5'd10, 5'd1, 5'd2, 4'h5, 5'd3), 1'b0, '0, '0, 1'b0, '0, '0);
        q.push_back(mk_exp(32'd7, 32'd3, 7'h00, 4'h5, 5'd3, 1'b0, '0, '0, 5'd10, 1'b1, 1'b0));
        tick();

        // Forward beats writeback on the same register
        drive(1'b1, mk_i(7'h01, 5'd11, 5'd4, 15'h7FFF), 1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
        q.push_back(mk_exp(32'hBB, 32'hFFFFFFFF, 7'h01, 4'h2, '0, 1'b0, '0, '0, 5'd11, 1'b1, 1'b0));
        tick();

        // Writeback landed in the file
        drive(1'b1, mk_r(5'd15, 5'd4, 5'd9, 4'h0, 5'd0), 1'b0, '0, '0, 1'b0, '0, '0);
        q.push_back(mk_exp(32'hAA, 32'hDEAD, 7'h00, 4'h0, '0, 1'b0, '0, '0, 5'd15, 1'b1, 1'b0));
        tick();

        // STORE with negative offset
        drive(1'b1, mk_i(7'h03, 5'd9, 5'd3, 15'h7FFC), 1'b0, '0, '0, 1'b0, '0, '0);
        q.push_back(mk_exp(32'h100, 32'hFFFFFFFC, 7'h03, 4'h2, '0, 1'b1, 32'hFC, 32'hDEAD,
                           5'd9, 1'b0, 1'b0));
        tick();

        // ADDI to R0 never writes back
        drive(1'b1, mk_i(7'h01, 5'd0, 5'd1, 15'd5), 1'b0, '0, '0, 1'b0, '0, '0);
        q.push_back(mk_exp(32'd7, 32'd5, 7'h01, 4'h2, '0, 1'b0, '0, '0, 5'd0, 1'b0, 1'b0));
        tick();

        // Unknown opcode is an all-zero valid bundle
        drive(1'b1, {7'h55, 25'h1ABCDEF}, 1'b0, '0, '0, 1'b0, '0, '0);
        #1 check("nop_in_ready", 32'(ifc.in_ready), 32'd1);
        q.push_back(mk_exp('0, '0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0));
        tick();

        // R0 reads 0 despite matching fwd and wb
        drive(1'b1, mk_r(5'd12, 5'd0, 5'd0, 4'h0, 5'd0), 1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77);
        q.push_back(mk_exp('0, '0, 7'h00, 4'h0, '0, 1'b0, '0, '0, 5'd12, 1'b1, 1'b0));
        tick();

        // Load-use on rs
        drive(1'b1, mk_i(7'h02, 5'd6, 5'd1, 15'd8), 1'b0, '0, '0, 1'b0, '0, '0);
        q.push_back(mk_exp(32'd7, 32'd8, 7'h02, 4'h2, '0, 1'b0, 32'd15, '0, 5'd6, 1'b1, 1'b1));
        tick();
        drive(1'b1, mk_r(5'd13, 5'd6, 5'd2, 4'h1, 5'd0), 1'b0, '0, '0, 1'b0, '0, '0);
        #1 check("lu_stall_ready", 32'(ifc.in_ready), 32'd0);
        tick();
        check("lu_bubble_valid", 32'(ifc.ex_valid), 32'd0);
        check("lu_bubble_busA", ifc.busA, 32'd0);
        drive(1'b1, mk_r(5'd13, 5'd6, 5'd2, 4'h1, 5'd0), 1'b1, 5'd6, 32'h1234, 1'b0, '0, '0);
        #1 check("lu_release_ready", 32'(ifc.in_ready), 32'd1);
        q.push_back(mk_exp(32'h1234, 32'd3, 7'h00, 4'h1, '0, 1'b0, '0, '0, 5'd13, 1'b1, 1'b0));
        tick();

        // Back-to-back loads stall independently
        drive(1'b1, mk_i(7'h02, 5'd7, 5'd0, 15'd0), 1'b0, '0, '0, 1'b0, '0, '0);
        q.push_back(mk_exp('0, '0, 7'h02, 4'h2, '0, 1'b0, '0, '0, 5'd7, 1'b1, 1'b1));
        tick();
        drive(1'b1, mk_i(7'h02, 5'd8, 5'd7, 15'd4), 1'b0, '0, '0, 1'b0, '0, '0);
        #1 check("bb_stall1_ready", 32'(ifc.in_ready), 32'd0);
        tick();
        drive(1'b1, mk_i(7'h02, 5'd8, 5'd7, 15'd4), 1'b1, 5'd7, 32'h40, 1'b0, '0, '0);
        #1 check("bb_release1_ready", 32'(ifc.in_ready), 32'd1);
        q.push_back(mk_exp(32'h40, 32'd4, 7'h02, 4'h2, '0, 1'b0, 32'h44, '0, 5'd8, 1'b1, 1'b1));
        tick();
        drive(1'b1, mk_r(5'd14, 5'd8, 5'd7, 4'h0, 5'd0), 1'b0, '0, '0, 1'b0, '0, '0);
        #1 check("bb_stall2_ready", 32'(ifc.in_ready), 32'd0);
        tick();
        drive(1'b1, mk_r(5'd14, 5'd8, 5'd7, 4'h0, 5'd0), 1'b1, 5'd8, 32'd5, 1'b0, '0, '0);
        #1 check("bb_release2_ready", 32'(ifc.in_ready), 32'd1);
        q.push_back(mk_exp(32'd5, 32'h40, 7'h00, 4'h0, '0, 1'b0, '0, '0, 5'd14, 1'b1, 1'b0));
        tick();

        // Reset asserted mid-stall (hazard through rt)
        drive(1'b1, mk_i(7'h02, 5'd6, 5'd0, 15'd0), 1'b0, '0, '0, 1'b0, '0, '0);
        q.push_back(mk_exp('0, '0, 7'h02, 4'h2, '0, 1'b0, '0, '0, 5'd6, 1'b1, 1'b1));
        tick();
        drive(1'b1, mk_r(5'd16, 5'd1, 5'd6, 4'h0, 5'd0), 1'b0, '0, '0, 1'b0, '0, '0);
        #1 check("rst_pre_stall_ready", 32'(ifc.in_ready), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(ifc.ex_valid), 32'd0);
        check("rst_async_memtoreg", 32'(ifc.ex_memtoreg), 32'd0);
        check("rst_async_opcode", 32'(ifc.opcode), 32'd0);
        check("rst_async_ready", 32'(ifc.in_ready), 32'd1);
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Registers cleared: R1 (was 7) and R5 read 0
        drive(1'b1, mk_r(5'd17, 5'd1, 5'd5, 4'h0, 5'd0), 1'b0, '0, '0, 1'b0, '0, '0);
        q.push_back(mk_exp('0, '0, 7'h00, 4'h0, '0, 1'b0, '0, '0, 5'd17, 1'b1, 1'b0));
        tick();
        idle();
        repeat (3) tick();

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
